// File: rtl/connection_block_cfg_loader.sv
// connection_block_cfg_loader: assembles a streamed switch bitstream in a shadow register and commits it to c atomically
module connection_block_cfg_loader #(
  parameter int CFG_BITS = 88,
  parameter int DW       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                clear,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CFG_BITS-1:0] c,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int NW = (CFG_BITS + DW - 1) / DW;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t              state, state_n;
  logic [NW*DW-1:0]    shadow, shadow_n;
  logic [CW-1:0]       count, count_n;
  logic [CFG_BITS-1:0] c_n;
  logic                busy_n, done_n, err_n;
  assign in_ready = state == LOAD;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      shadow <= '0;
      count  <= '0;
      c      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      count  <= count_n;
      c      <= c_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    count_n  = count;
    c_n      = c;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          c_n      = '0;
          shadow_n = '0;
        end else if (start) begin
          count_n = '0;
          state_n = LOAD;
          busy_n  = 1'b1;
        end
      end
      LOAD: begin
        // abort outranks a simultaneous accept, so the word in flight is dropped
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end else if (in_valid) begin
          shadow_n[count*DW +: DW] = in_data;
          count_n = count + 1'b1;
          state_n = count == CW'(NW - 1) ? COMMIT : LOAD;
        end
      end
      COMMIT: begin
        c_n     = shadow[CFG_BITS-1:0];
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_connection_block_cfg_loader.sv
// tb_connection_block_cfg_loader: table vectors, directed corner sequences and random stimulus against a word-list model
module tb_connection_block_cfg_loader;
  localparam int CB = 88;
  localparam int NW = 11;
  logic          clk = 0, rst_n = 0, start = 0, abort = 0, clear = 0, in_valid = 0;
  logic [7:0]    in_data = '0;
  logic          in_ready, busy, done, err;
  logic [CB-1:0] c;
  int            n_chk = 0, n_fail = 0;
  bit            m_load, m_commit, m_busy, m_done, m_err;
  int            m_n;
  logic [7:0]    m_w[NW];
  logic [CB-1:0] m_c;
  typedef struct {
    bit st, ab, cl, v;
    logic [7:0] d;
    bit eb, er, ed, ee;
    logic [CB-1:0] ec;
  } vec_t;
  vec_t          tv[16];
  logic [7:0]    pa[NW], p1[NW], p2[NW], p3[NW];
  logic [CB-1:0] pa_c;

  always #5 clk = ~clk;

  connection_block_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [CB-1:0] pack(input logic [7:0] w[NW]);
    logic [CB-1:0] r = '0;
    for (int k = 0; k < NW; k++) r |= CB'(w[k]) << (k * 8);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [CB-1:0] a, input logic [CB-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // one clock: apply inputs, advance the model by one edge, compare everything
  task automatic step(input bit r, input bit st, input bit ab, input bit cl, input bit v, input logic [7:0] d);
    rst_n = r; start = st; abort = ab; clear = cl; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    m_done = 0;
    m_err  = 0;
    if (!r) begin
      m_load = 0; m_commit = 0; m_busy = 0; m_n = 0; m_c = '0;
    end else if (m_commit) begin
      m_c = pack(m_w); m_done = 1; m_commit = 0; m_busy = 0;
    end else if (m_load) begin
      if (ab) begin
        m_load = 0; m_busy = 0; m_err = 1;
      end else if (v) begin
        m_w[m_n] = d;
        m_n++;
        if (m_n == NW) begin
          m_load = 0; m_commit = 1;
        end
      end
    end else if (cl) begin
      m_c = '0;
    end else if (st) begin
      m_load = 1; m_n = 0; m_busy = 1;
    end
    chk("model_c", c, m_c);
    chk("model_busy", CB'(busy), CB'(m_busy));
    chk("model_ready", CB'(in_ready), CB'(m_load));
    chk("model_done", CB'(done), CB'(m_done));
    chk("model_err", CB'(err), CB'(m_err));
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic load(input logic [7:0] w[NW], input bit bub);
    step(1, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < NW; k++) begin
      if (bub)
        repeat ($urandom_range(2, 4)) step(1, 0, 0, 0, 0, 8'($urandom));
      step(1, 0, 0, 0, 1, w[k]);
    end
    idle();
    idle();
  endtask

  initial begin
    for (int k = 0; k < NW; k++) begin
      pa[k] = 8'hA0 + 8'(k);
      p1[k] = 8'($urandom);
      p2[k] = 8'($urandom);
      p3[k] = 8'($urandom);
    end
    pa_c = {8'hAA, 8'hA9, 8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tv[0] = '{1, 0, 0, 0, 8'h00, 1, 1, 0, 0, '0};
    for (int k = 0; k < NW; k++)
      tv[1 + k] = '{0, 0, 0, 1, 8'hA0 + 8'(k), 1, k < NW - 1, 0, 0, '0};
    tv[12] = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 0, pa_c};
    tv[13] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, pa_c};
    tv[14] = '{1, 0, 1, 0, 8'h00, 0, 0, 0, 0, '0};
    tv[15] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, '0};

    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 1, 8'hFF);
    chk("rst_c", c, '0);
    chk("rst_busy", CB'(busy), '0);
    chk("rst_ready", CB'(in_ready), '0);
    chk("rst_done", CB'(done), '0);
    chk("rst_err", CB'(err), '0);

    for (int i = 0; i < 16; i++) begin
      step(1, tv[i].st, tv[i].ab, tv[i].cl, tv[i].v, tv[i].d);
      chk($sformatf("tbl%0d_busy", i), CB'(busy), CB'(tv[i].eb));
      chk($sformatf("tbl%0d_ready", i), CB'(in_ready), CB'(tv[i].er));
      chk($sformatf("tbl%0d_done", i), CB'(done), CB'(tv[i].ed));
      chk($sformatf("tbl%0d_err", i), CB'(err), CB'(tv[i].ee));
      chk($sformatf("tbl%0d_c", i), c, tv[i].ec);
    end

    load(pa, 1);
    chk("bubble_c", c, pa_c);

    load(p1, 0);
    chk("p1_c", c, pack(p1));
    step(1, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 1, p2[k]);
    step(1, 0, 1, 0, 1, 8'h5A);
    chk("abort_err", CB'(err), CB'(1));
    chk("abort_c", c, pack(p1));
    chk("abort_ready", CB'(in_ready), '0);
    idle();
    load(p2, 0);
    chk("p2_c", c, pack(p2));
    chk("p2_word0", CB'(c[7:0]), CB'(p2[0]));

    step(1, 1, 0, 1, 0, 8'h00);
    chk("clear_c", c, '0);
    chk("clear_busy", CB'(busy), '0);
    idle();
    chk("clear_idle", CB'(in_ready), '0);

    step(1, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < NW; k++) step(1, k == 4, 0, k == 6, 1, p1[k]);
    chk("busy_start_commit", CB'(busy), CB'(1));
    idle();
    chk("busy_start_c", c, pack(p1));
    chk("busy_start_done", CB'(done), CB'(1));
    idle();

    step(1, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 1, p3[k]);
    step(0, 0, 0, 0, 1, 8'h77);
    chk("midrst_c", c, '0);
    chk("midrst_ready", CB'(in_ready), '0);
    load(p3, 1);
    chk("p3_c", c, pack(p3));

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0, 1'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
